// File: rtl/clarvi_mem_pkg.sv
// ============================================================================
// clarvi_mem_pkg : shared types and constants for the CLARVI data memory
// Revision: 1.0
// ============================================================================
`default_nettype none

package clarvi_mem_pkg;

  localparam int LANE_WIDTH = 8;
  localparam int NUM_LANES  = 2;
  localparam int WORD_WIDTH = LANE_WIDTH * NUM_LANES;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    BUSY = ST_BUSY
  } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/clarvi_dmem_bank.sv
// ============================================================================
// clarvi_dmem_bank : one byte lane of data memory with a read-before-write
//                    capture register
// Revision: 1.0
// ============================================================================
`default_nettype none

module clarvi_dmem_bank
  import clarvi_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic [IDX_W-1:0]      i_idx,
  input  logic [LANE_WIDTH-1:0] i_wdata,
  output logic [LANE_WIDTH-1:0] o_rdata
);

  logic [LANE_WIDTH-1:0] r_mem [DEPTH];
  logic [LANE_WIDTH-1:0] r_rdata;

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/clarvi_data_mem.sv
// ============================================================================
// clarvi_data_mem : 16-bit byte-enabled data memory, READ_LATENCY 1..4
// Optional bounds checking via macro CLARVI_DMEM_BOUNDS_CHECK_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module clarvi_data_mem
  import clarvi_mem_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = 14,
  parameter int MEM_WORDS       = 2**DATA_ADDR_WIDTH,
  parameter int READ_LATENCY    = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [DATA_ADDR_WIDTH-1:0] main_address,
  input  logic [NUM_LANES-1:0]       main_byte_enable,
  input  logic                       main_read_enable,
  input  logic                       main_write_enable,
  input  logic [WORD_WIDTH-1:0]      main_write_data,
  output logic [WORD_WIDTH-1:0]      main_read_data,
  output logic                       main_read_valid,
  output logic                       main_wait,
  output logic                       main_error
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int CNT_W = 2;

  logic                  w_wait;
  logic                  w_valid;
  logic                  w_oob;
  logic                  w_accept;
  logic                  w_rd_acc;
  logic                  w_wr_acc;
  logic [IDX_W-1:0]      w_idx;
  logic [WORD_WIDTH-1:0] w_resp;
  logic [LANE_WIDTH-1:0] w_lane_rd [NUM_LANES];
  logic                  w_unused;

  logic [NUM_LANES-1:0]  r_be;
  logic                  r_err;
  logic [WORD_WIDTH-1:0] r_last;

`ifdef CLARVI_DMEM_BOUNDS_CHECK_EN
  assign w_oob = ({1'b0, main_address} >= (DATA_ADDR_WIDTH+1)'(MEM_WORDS));
`else
  assign w_oob = 1'b0;
`endif

  // Low index bits give modulo-MEM_WORDS aliasing when bounds checking is off.
  assign w_idx    = main_address[IDX_W-1:0];
  assign w_accept = !reset && !w_wait;
  assign w_rd_acc = w_accept && main_read_enable;
  assign w_wr_acc = w_accept && main_write_enable;
  assign w_unused = ^{main_address, r_err};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    clarvi_dmem_bank #(
      .DEPTH (MEM_WORDS),
      .IDX_W (IDX_W)
    ) u_bank (
      .clk     (clock),
      .rst     (reset),
      .i_we    (w_wr_acc && main_byte_enable[g] && !w_oob),
      .i_re    (w_rd_acc),
      .i_idx   (w_idx),
      .i_wdata (main_write_data[g*LANE_WIDTH +: LANE_WIDTH]),
      .o_rdata (w_lane_rd[g])
    );
    assign w_resp[g*LANE_WIDTH +: LANE_WIDTH] = r_be[g] ? w_lane_rd[g] : '0;
  end

  // Lane mask and error flag travel with the read; an out-of-range read masks all lanes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_be   <= '0;
      r_err  <= 1'b0;
      r_last <= '0;
    end else begin
      if (w_rd_acc) begin
        r_be  <= w_oob ? '0 : main_byte_enable;
        r_err <= w_oob;
      end
      if (w_valid) begin
        r_last <= w_resp;
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_pipe
    logic r_pend;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_pend <= 1'b0;
      end else begin
        r_pend <= w_rd_acc;
      end
    end

    assign w_valid = r_pend;
    assign w_wait  = 1'b0;
  end else begin : g_fsm
    dmem_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;

    assign w_valid = (r_state == BUSY) && (r_cnt == '0);
    assign w_wait  = (r_state == BUSY) && (r_cnt != '0);

    // In the valid cycle wait is already low, so a new read may reload the counter.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else if (r_state == IDLE) begin
        if (w_rd_acc) begin
          r_state <= BUSY;
          r_cnt   <= CNT_W'(READ_LATENCY - 1);
        end
      end else if (r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end else if (w_rd_acc) begin
        r_cnt <= CNT_W'(READ_LATENCY - 1);
      end else begin
        r_state <= IDLE;
      end
    end
  end

  assign main_read_valid = w_valid;
  assign main_read_data  = w_valid ? w_resp : r_last;
  assign main_wait       = w_wait;

`ifdef CLARVI_DMEM_BOUNDS_CHECK_EN
  assign main_error = (w_valid && r_err) || (w_wr_acc && w_oob);
`else
  assign main_error = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clarvi_data_mem.sv
// ============================================================================
// tb_clarvi_data_mem : directed + random checks of clarvi_data_mem at
// READ_LATENCY 1 (MEM_WORDS 1024) and READ_LATENCY 3 against a word-array model
// ============================================================================
`default_nettype none

module tb_clarvi_data_mem;

`ifdef CLARVI_DMEM_BOUNDS_CHECK_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [13:0] a_addr, b_addr;
  logic [1:0]  a_be, b_be;
  logic        a_re, a_we, b_re, b_we;
  logic [15:0] a_wd, a_rd, b_wd, b_rd;
  logic        a_rv, a_wait, a_err, b_rv, b_wait, b_err;

  clarvi_data_mem #(.DATA_ADDR_WIDTH(14), .MEM_WORDS(1024), .READ_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .main_address(a_addr), .main_byte_enable(a_be),
    .main_read_enable(a_re), .main_write_enable(a_we), .main_write_data(a_wd),
    .main_read_data(a_rd), .main_read_valid(a_rv), .main_wait(a_wait), .main_error(a_err));

  clarvi_data_mem #(.DATA_ADDR_WIDTH(14), .MEM_WORDS(256), .READ_LATENCY(3)) dut_b (
    .clock(clock), .reset(reset), .main_address(b_addr), .main_byte_enable(b_be),
    .main_read_enable(b_re), .main_write_enable(b_we), .main_write_data(b_wd),
    .main_read_data(b_rd), .main_read_valid(b_rv), .main_wait(b_wait), .main_error(b_err));

  int total = 0;
  int bad   = 0;

  // Reference state: plain word arrays plus "what is owed to the requester".
  logic [15:0] ma [1024];
  bit          apv, ape;
  logic [15:0] apd, ald;
  logic [15:0] mb [256];
  bit          binf;
  int          brem;
  logic [15:0] bpd, bld;
  logic [15:0] a_obs_d, b_obs_d;
  logic        a_obs_v, a_obs_e, b_obs_v, b_obs_w;

  function automatic logic [15:0] mask16(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic a_cycle(input logic we, input logic re, input logic [13:0] addr,
                         input logic [1:0] be, input logic [15:0] wd, input string tag);
    bit          oob, exp_v, exp_e;
    int          idx;
    logic [15:0] exp_d;
    a_we = we; a_re = re; a_addr = addr; a_be = be; a_wd = wd;
    oob   = BC && (int'(addr) >= 1024);
    idx   = int'(addr) % 1024;
    exp_v = apv;
    exp_d = apv ? apd : ald;
    exp_e = (apv && ape) || (we && oob);
    @(negedge clock);
    a_obs_d = a_rd; a_obs_v = a_rv; a_obs_e = a_err;
    check({tag, ".valid"}, 16'(a_rv), 16'(exp_v));
    check({tag, ".data"}, a_rd, exp_d);
    check({tag, ".err"}, 16'(a_err), 16'(exp_e));
    check({tag, ".wait"}, 16'(a_wait), 16'd0);
    if (exp_v) ald = apd;
    if (re) begin
      apd = oob ? 16'h0000 : (ma[idx] & mask16(be));
      ape = oob;
    end
    apv = re;
    if (we && !oob) ma[idx] = (ma[idx] & ~mask16(be)) | (wd & mask16(be));
    @(posedge clock); #1;
  endtask

  task automatic b_cycle(input logic we, input logic re, input logic [13:0] addr,
                         input logic [1:0] be, input logic [15:0] wd, input string tag);
    bit          exp_v, exp_w;
    int          idx;
    logic [15:0] exp_d;
    b_we = we; b_re = re; b_addr = addr; b_be = be; b_wd = wd;
    idx = int'(addr) % 256;
    if (binf && brem > 0) brem--;
    exp_v = binf && (brem == 0);
    exp_w = binf && (brem > 0);
    exp_d = exp_v ? bpd : bld;
    @(negedge clock);
    b_obs_d = b_rd; b_obs_v = b_rv; b_obs_w = b_wait;
    check({tag, ".valid"}, 16'(b_rv), 16'(exp_v));
    check({tag, ".data"}, b_rd, exp_d);
    check({tag, ".wait"}, 16'(b_wait), 16'(exp_w));
    check({tag, ".err"}, 16'(b_err), 16'd0);
    if (exp_v) begin
      bld  = bpd;
      binf = 1'b0;
    end
    if (!exp_w && re) begin
      bpd  = mb[idx] & mask16(be);
      binf = 1'b1;
      brem = 3;
    end
    if (!exp_w && we) mb[idx] = (mb[idx] & ~mask16(be)) | (wd & mask16(be));
    @(posedge clock); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".a_rd"}, a_rd, 16'h0);
    check({tag, ".a_ctl"}, {13'd0, a_rv, a_wait, a_err}, 16'h0);
    check({tag, ".b_rd"}, b_rd, 16'h0);
    check({tag, ".b_ctl"}, {13'd0, b_rv, b_wait, b_err}, 16'h0);
  endtask

  task automatic model_reset();
    apv = 1'b0; ape = 1'b0; ald = 16'h0;
    binf = 1'b0; brem = 0; bld = 16'h0;
  endtask

  initial begin
    a_we = 0; a_re = 0; a_addr = 0; a_be = 0; a_wd = 0;
    b_we = 0; b_re = 0; b_addr = 0; b_be = 0; b_wd = 0;
    reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset");
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;

    // Basic write then read
    a_cycle(1, 0, 14'h010, 2'b11, 16'hBEEF, "w_beef");
    a_cycle(0, 1, 14'h010, 2'b11, 16'h0, "r_beef");
    a_cycle(0, 0, 14'h0, 2'b00, 16'h0, "v_beef");
    check("beef_valid", 16'(a_obs_v), 16'd1);
    check("beef_data", a_obs_d, 16'hBEEF);
    a_cycle(0, 0, 14'h0, 2'b00, 16'h0, "hold");
    check("hold_data", a_obs_d, 16'hBEEF);

    // Partial lane writes and masked reads, back-to-back valids
    a_cycle(1, 0, 14'h020, 2'b11, 16'h1234, "w1234");
    a_cycle(1, 0, 14'h020, 2'b10, 16'hAB00, "wab00");
    a_cycle(1, 0, 14'h020, 2'b00, 16'hFFFF, "wbe00");
    a_cycle(0, 1, 14'h020, 2'b11, 16'h0, "r_be11");
    a_cycle(0, 1, 14'h020, 2'b01, 16'h0, "r_be01");
    check("ab34", a_obs_d, 16'hAB34);
    a_cycle(0, 0, 14'h0, 2'b00, 16'h0, "v_be01");
    check("0034", a_obs_d, 16'h0034);
    check("b2b_valid", 16'(a_obs_v), 16'd1);

    // Read-before-write on collision, then read-after-write
    a_cycle(1, 0, 14'h030, 2'b11, 16'h0F0F, "w0f0f");
    a_cycle(1, 1, 14'h030, 2'b11, 16'h5555, "rw_same");
    a_cycle(0, 1, 14'h030, 2'b11, 16'h0, "r_after");
    check("rbw_old", a_obs_d, 16'h0F0F);
    a_cycle(0, 0, 14'h0, 2'b00, 16'h0, "v_after");
    check("raw_new", a_obs_d, 16'h5555);

    // Out-of-range address: error/suppress when checked, alias otherwise
    a_cycle(1, 0, 14'h000, 2'b11, 16'h1111, "w_zero");
    a_cycle(1, 0, 14'h400, 2'b11, 16'hDEAD, "w_oob");
    check("oob_werr", 16'(a_obs_e), 16'(BC));
    a_cycle(0, 1, 14'h000, 2'b11, 16'h0, "r_zero");
    a_cycle(0, 1, 14'h400, 2'b11, 16'h0, "r_oob");
    check("zero_data", a_obs_d, BC ? 16'h1111 : 16'hDEAD);
    a_cycle(0, 0, 14'h0, 2'b00, 16'h0, "v_oob");
    check("oob_rdata", a_obs_d, BC ? 16'h0000 : 16'hDEAD);
    check("oob_rerr", 16'(a_obs_e), 16'(BC));

    // Random traffic on the latency-1 instance
    for (int i = 0; i < 16; i++) a_cycle(1, 0, 14'(i), 2'b11, 16'($urandom), "a_init");
    for (int i = 0; i < 200; i++) begin
      logic [13:0] ad;
      ad = ($urandom_range(0, 7) == 0) ? 14'(1024 + $urandom_range(0, 15))
                                       : 14'($urandom_range(0, 15));
      a_cycle(1'($urandom), 1'($urandom), ad, 2'($urandom), 16'($urandom), "a_rand");
    end
    a_cycle(0, 0, 14'h0, 2'b00, 16'h0, "a_drain");

    // Latency-3 handshake: ignored request while waiting, accept in valid cycle
    b_cycle(1, 0, 14'h005, 2'b11, 16'hCAFE, "b_init5");
    b_cycle(0, 1, 14'h005, 2'b11, 16'h0, "b_t0");
    check("t0_wait", 16'(b_obs_w), 16'd0);
    b_cycle(1, 1, 14'h005, 2'b11, 16'h0000, "b_t1");
    check("t1_wait", 16'(b_obs_w), 16'd1);
    b_cycle(0, 0, 14'h0, 2'b00, 16'h0, "b_t2");
    check("t2_wait", 16'(b_obs_w), 16'd1);
    b_cycle(0, 1, 14'h005, 2'b01, 16'h0, "b_t3");
    check("t3_valid", 16'(b_obs_v), 16'd1);
    check("t3_data", b_obs_d, 16'hCAFE);
    check("t3_wait", 16'(b_obs_w), 16'd0);
    b_cycle(0, 0, 14'h0, 2'b00, 16'h0, "b_t4");
    b_cycle(0, 0, 14'h0, 2'b00, 16'h0, "b_t5");
    b_cycle(0, 0, 14'h0, 2'b00, 16'h0, "b_t6");
    check("t6_data", b_obs_d, 16'h00FE);

    // Reset in the middle of a latency-3 read
    b_cycle(0, 1, 14'h005, 2'b11, 16'h0, "b_rst_t0");
    b_re = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    b_cycle(0, 0, 14'h0, 2'b00, 16'h0, "b_post1");
    b_cycle(0, 0, 14'h0, 2'b00, 16'h0, "b_post2");
    check("post_novalid", 16'(b_obs_v), 16'd0);
    check("post_data", b_obs_d, 16'h0);

    // Random traffic on the latency-3 instance
    for (int i = 0; i < 16; i++) b_cycle(1, 0, 14'(i), 2'b11, 16'($urandom), "b_init");
    for (int i = 0; i < 150; i++) begin
      b_cycle(1'($urandom), 1'($urandom), 14'($urandom_range(0, 15)), 2'($urandom),
              16'($urandom), "b_rand");
    end
    for (int i = 0; i < 4; i++) b_cycle(0, 0, 14'h0, 2'b00, 16'h0, "b_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
